// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width and the
// stereo packetizer state encoding.
package audio_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND_L,
    SEND_R
  } tx_state_e;

  // Width of an occupancy counter that must hold 0..depth.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO.
// Ports: clk, rst (async, active-high), push, pop,
// din, dout (current head), level, full, empty.
module sync_sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the
  // pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so pointers
  // wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mono_sample_to_packet_converter.sv
// Mono strobe -> 2-beat stereo AXI4-Stream packets.
// Ports: M_AXIS_* master stream, mono_sample(_valid),
// fifo_level, sticky overflow, saturating drop_count.
module mono_sample_to_packet_converter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH       = audio_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH       = 4,
  parameter int DROP_COUNT_WIDTH = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                        M_AXIS_ACLK,
  input  logic                        M_AXIS_ARESET,
  input  logic                        mono_sample_valid,
  input  logic [DATA_WIDTH-1:0]       mono_sample,
  output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic                        M_AXIS_TVALID,
  output logic                        M_AXIS_TLAST,
  input  logic                        M_AXIS_TREADY,
  output logic [LW-1:0]               fifo_level,
  output logic                        overflow,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  logic                  clk;
  logic                  rst;
  tx_state_e             state;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  drop;

  assign clk = M_AXIS_ACLK;
  assign rst = M_AXIS_ARESET;

  // Full check uses the registered level:
  // a same-cycle pop does not save a write.
  assign fifo_push = mono_sample_valid && !fifo_full;
  assign drop      = mono_sample_valid && fifo_full;

  // Pop whenever the bus register is about to
  // take a new left beat.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (1'b1)
      (state == IDLE):
        fifo_pop = !fifo_empty;
      (state == SEND_R):
        fifo_pop = !fifo_empty && M_AXIS_TREADY;
      default:
        fifo_pop = 1'b0;
    endcase
  end

  sync_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mono_sample),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            M_AXIS_TDATA  <= fifo_dout;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= 1'b0;
            state         <= SEND_L;
          end
        end
        SEND_L: begin
          // Same sample is replayed as the right beat.
          if (M_AXIS_TREADY) begin
            M_AXIS_TLAST <= 1'b1;
            state        <= SEND_R;
          end
        end
        SEND_R: begin
          if (M_AXIS_TREADY) begin
            if (!fifo_empty) begin
              M_AXIS_TDATA <= fifo_dout;
              M_AXIS_TLAST <= 1'b0;
              state        <= SEND_L;
            end else begin
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          M_AXIS_TVALID <= 1'b0;
          M_AXIS_TLAST  <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mono_sample_to_packet_converter.sv
// Scoreboard bench for the mono-to-stereo packetizer.
// Stimulus queues expected beats; a monitor checks them.
module tb_mono_sample_to_packet_converter;

  localparam int DW = 32;
  localparam int FD = 4;
  localparam int CW = 2;
  localparam int LW = $clog2(FD + 1);

  logic          clk;
  logic          rst;
  logic          sv;
  logic [DW-1:0] sd;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  logic [LW-1:0] level;
  logic          ovf;
  logic [CW-1:0] dcnt;

  int checks   = 0;
  int failures = 0;

  logic [DW:0] exp_q [$];

  mono_sample_to_packet_converter #(
    .DATA_WIDTH       (DW),
    .FIFO_DEPTH       (FD),
    .DROP_COUNT_WIDTH (CW)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (rst),
    .mono_sample_valid (sv),
    .mono_sample       (sd),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready),
    .fifo_level        (level),
    .overflow          (ovf),
    .drop_count        (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one strobe for a cycle; queue
  // both beats unless the sample will drop.
  task automatic strobe(input logic [DW-1:0] d,
                        input bit keep);
    sv = 1'b1;
    sd = d;
    if (keep) begin
      exp_q.push_back({1'b0, d});
      exp_q.push_back({1'b1, d});
    end
    tick();
    sv = 1'b0;
    sd = '0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 60) begin
      tick();
      n++;
    end
    chk(nm, 64'(n < 60), 64'd1);
  endtask

  // Monitor: sampled at negedge, so the values
  // seen hold through the coming posedge.
  logic          hold;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  logic [DW:0]   e;

  initial hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", 64'(tdata), 64'(hold_d));
        chk("hold_last", 64'(tlast), 64'(hold_l));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(tdata), 64'hx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(tdata), 64'(e[DW-1:0]));
          chk("beat_last", 64'(tlast), 64'(e[DW]));
        end
      end
      hold   = tvalid && !tready;
      hold_d = tdata;
      hold_l = tlast;
    end
  end

  initial begin
    logic [DW-1:0] v [6];
    v[0] = 32'hA0000100;
    v[1] = 32'hB0000200;
    v[2] = 32'hC0000300;
    v[3] = 32'hD0000400;
    v[4] = 32'hE0000500;
    v[5] = 32'hF0000600;

    rst    = 1'b1;
    sv     = 1'b0;
    sd     = '0;
    tready = 1'b0;
    #12;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_dcnt", 64'(dcnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single sample, latency and framing.
    tready = 1'b1;
    strobe(32'h12345600, 1'b1);
    chk("lat_c1_level", 64'(level), 64'd1);
    chk("lat_c1_tvalid", 64'(tvalid), 64'd0);
    tick();
    chk("lat_c2_tvalid", 64'(tvalid), 64'd1);
    chk("lat_c2_tlast", 64'(tlast), 64'd0);
    chk("lat_c2_tdata", 64'(tdata), 64'h12345600);
    chk("lat_c2_level", 64'(level), 64'd0);
    tick();
    chk("lat_c3_tlast", 64'(tlast), 64'd1);
    chk("lat_c3_tdata", 64'(tdata), 64'h12345600);
    tick();
    chk("lat_c4_tvalid", 64'(tvalid), 64'd0);
    tick();

    // Back-pressure stall.
    tready = 1'b0;
    strobe(32'hFFFFFF00, 1'b1);
    repeat (10) tick();
    chk("bp_tvalid", 64'(tvalid), 64'd1);
    chk("bp_tlast", 64'(tlast), 64'd0);
    chk("bp_tdata", 64'(tdata), 64'hFFFFFF00);
    tready = 1'b1;
    tick();
    chk("bp_r_tlast", 64'(tlast), 64'd1);
    chk("bp_r_tvalid", 64'(tvalid), 64'd1);
    tick();
    chk("bp_end_tvalid", 64'(tvalid), 64'd0);

    // Overflow: A on bus, B-E buffered, F dropped.
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(v[i], i < 5);
    end
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_dcnt", 64'(dcnt), 64'd1);
    chk("ovf_head", 64'(tdata), 64'(v[0]));
    tready = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Back-to-back: six beats, no bubble.
    for (int c = 0; c < 9; c++) begin
      if (c < 3) strobe(v[c], 1'b1);
      else tick();
      if (c + 1 >= 2 && c + 1 <= 7) begin
        chk("b2b_tvalid", 64'(tvalid), 64'd1);
        chk("b2b_tlast", 64'(tlast), 64'((c + 1) % 2));
      end
      if (c + 1 == 8) begin
        chk("b2b_idle", 64'(tvalid), 64'd0);
      end
    end
    drain("b2b_drain");

    // Reset during SEND_R with two buffered.
    tready = 1'b0;
    strobe(v[3], 1'b1);
    strobe(v[4], 1'b0);
    strobe(v[5], 1'b0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    chk("mid_tlast", 64'(tlast), 64'd1);
    chk("mid_level", 64'(level), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    tick();
    rst    = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", 64'(tvalid), 64'd0);
    end

    // Drop-counter saturation at 2 bits.
    tready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      strobe(32'h01010100 * (i + 1), i < 5);
      if (i == 7) begin
        chk("sat_first", 64'(dcnt), 64'd3);
      end
    end
    chk("sat_dcnt", 64'(dcnt), 64'd3);
    chk("sat_ovf", 64'(ovf), 64'd1);
    tready = 1'b1;
    drain("sat_drain");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
